// File: rtl/div_scheduler_if.sv
// Request/result bundle between the per-thread ALUs and the shared divider.
// Handshake: a thread holds req[i] with stable intent until done[i] pulses for one
// cycle; result is valid only while a done bit is high; busy/grant_id describe the
// divide currently in flight.
interface div_scheduler_if #(
  parameter int THREADS   = 4,
  parameter int DATA_BITS = 8
);
  localparam int ID_W = $clog2(THREADS);

  logic [THREADS-1:0]           req;
  logic [THREADS*DATA_BITS-1:0] rs;
  logic [THREADS*DATA_BITS-1:0] rt;
  logic [THREADS-1:0]           done;
  logic [DATA_BITS-1:0]         result;
  logic                         busy;
  logic [ID_W-1:0]              grant_id;

  modport master (
    output req, rs, rt,
    input  done, result, busy, grant_id
  );

  modport slave (
    input  req, rs, rt,
    output done, result, busy, grant_id
  );
endinterface

// File: rtl/div_scheduler.sv
// Shared iterative signed divider with a round-robin scheduler: one restoring
// divide in flight at a time, one quotient bit per cycle, result on a shared bus.
module div_scheduler #(
  parameter int THREADS   = 4,
  parameter int DATA_BITS = 8
) (
  input  logic             clk,
  input  logic             reset,
  div_scheduler_if.slave   bus,
  output logic [1:0]       dbg_state
);

  localparam int ID_W  = $clog2(THREADS);
  localparam int CNT_W = $clog2(DATA_BITS);
  localparam logic [ID_W-1:0]  LAST_INIT = ID_W'(THREADS - 1);
  localparam logic [ID_W:0]    THREADS_W = (ID_W + 1)'(THREADS);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DATA_BITS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t state, next_state;

  logic [ID_W-1:0]      last, gid, win;
  logic                 found;
  logic [DATA_BITS-1:0] rs_arr [THREADS];
  logic [DATA_BITS-1:0] rt_arr [THREADS];
  logic [DATA_BITS-1:0] rs_win, rt_win;
  logic                 rt_zero;
  logic [DATA_BITS-1:0] rem, quo, dvs;
  logic                 sign;
  logic [CNT_W-1:0]     cnt;
  logic [DATA_BITS:0]   shifted, diff;
  logic                 qbit;
  logic [THREADS-1:0]   done_r;
  logic [DATA_BITS-1:0] result_r;

  function automatic logic [DATA_BITS-1:0] mag(input logic [DATA_BITS-1:0] x);
    // Two's-complement negate of the most negative value wraps to itself, which
    // read as unsigned is exactly its magnitude.
    return x[DATA_BITS-1] ? -x : x;
  endfunction

  function automatic logic [THREADS-1:0] onehot(input logic [ID_W-1:0] i);
    logic [THREADS-1:0] v;
    v    = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  always_comb begin
    for (int t = 0; t < THREADS; t++) begin
      rs_arr[t] = bus.rs[t*DATA_BITS +: DATA_BITS];
      rt_arr[t] = bus.rt[t*DATA_BITS +: DATA_BITS];
    end
  end

  // Round-robin: scan from last+1 upward, wrapping, first requester wins.
  always_comb begin
    logic [ID_W:0] sum;
    found = 1'b0;
    win   = '0;
    sum   = '0;
    for (int k = 1; k <= THREADS; k++) begin
      sum = {1'b0, last} + (ID_W + 1)'(k);
      if (sum >= THREADS_W) sum = sum - THREADS_W;
      if (!found && bus.req[sum[ID_W-1:0]]) begin
        found = 1'b1;
        win   = sum[ID_W-1:0];
      end
    end
  end

  assign rs_win  = rs_arr[win];
  assign rt_win  = rt_arr[win];
  assign rt_zero = (rt_win == '0);

  // Borrow out of the trial subtraction decides the quotient bit.
  assign shifted = {rem, quo[DATA_BITS-1]};
  assign diff    = shifted - {1'b0, dvs};
  assign qbit    = ~diff[DATA_BITS];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: if (found) next_state = rt_zero ? DONE : ITER;
      ITER: if (cnt == CNT_LAST) next_state = FIX;
      FIX:  next_state = DONE;
      DONE: next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last     <= LAST_INIT;
      gid      <= '0;
      rem      <= '0;
      quo      <= '0;
      dvs      <= '0;
      sign     <= 1'b0;
      cnt      <= '0;
      done_r   <= '0;
      result_r <= '0;
    end else begin
      done_r <= '0;
      case (state)
        IDLE: begin
          if (found) begin
            gid  <= win;
            last <= win;
            sign <= rs_win[DATA_BITS-1] ^ rt_win[DATA_BITS-1];
            quo  <= mag(rs_win);
            dvs  <= mag(rt_win);
            rem  <= '0;
            cnt  <= '0;
            if (rt_zero) begin
              result_r <= '1;
              done_r   <= onehot(win);
            end
          end
        end
        ITER: begin
          rem <= qbit ? diff[DATA_BITS-1:0] : shifted[DATA_BITS-1:0];
          quo <= {quo[DATA_BITS-2:0], qbit};
          cnt <= cnt + CNT_W'(1);
        end
        FIX: begin
          result_r <= sign ? -quo : quo;
          done_r   <= onehot(gid);
        end
        default: ;
      endcase
    end
  end

  assign bus.done     = done_r;
  assign bus.result   = result_r;
  assign bus.busy     = (state != IDLE);
  assign bus.grant_id = gid;
  assign dbg_state    = state;

endmodule

// File: tb/tb_div_scheduler.sv
// Directed bench for div_scheduler: latency, signed cases, divide by zero,
// round-robin order, operand stability and asynchronous reset mid-divide.
module tb_div_scheduler;

  localparam int THREADS = 4;
  localparam int DW      = 8;
  localparam int MAXW    = 40;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ITER = 2'd1;

  logic       clk;
  logic       reset;
  logic [1:0] dbg_state;

  div_scheduler_if #(.THREADS(THREADS), .DATA_BITS(DW)) bus ();

  div_scheduler #(.THREADS(THREADS), .DATA_BITS(DW)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  int total = 0;
  int bad   = 0;

  logic [DW-1:0]      exp_q[$];
  logic [THREADS-1:0] exp_done_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // driver tasks
  task automatic set_ops(input int t, input logic [DW-1:0] a, input logic [DW-1:0] b);
    bus.rs[t*DW +: DW] = a;
    bus.rt[t*DW +: DW] = b;
  endtask

  task automatic expect_done(input int t, input logic [DW-1:0] r);
    exp_q.push_back(r);
    exp_done_q.push_back(THREADS'(1) << t);
  endtask

  // Waits for any done bit; lat is the index of the sampling negedge (0 = right
  // after the next rising edge), busy_n counts samples with busy high.
  task automatic wait_done(output logic [THREADS-1:0] d, output int lat,
                           output int busy_n, output logic [1:0] first_gid);
    logic timed_out;
    timed_out = 1'b1;
    d         = '0;
    lat       = -1;
    busy_n    = 0;
    first_gid = '0;
    for (int i = 0; i < MAXW; i++) begin
      @(negedge clk);
      if (i == 0) first_gid = bus.grant_id;
      if (bus.busy) busy_n++;
      if (bus.done != '0) begin
        d         = bus.done;
        lat       = i;
        timed_out = 1'b0;
        break;
      end
    end
    check("wait_timeout", 32'(timed_out), 0);
  endtask

  // scoreboard: compare a done sample against the expected queue
  task automatic sb_done(input logic [THREADS-1:0] d);
    if (exp_q.size() == 0) begin
      check("sb_underflow", 32'(d), 0);
    end else begin
      check("done_thread", 32'(d), 32'(exp_done_q.pop_front()));
      check("result", 32'(bus.result), 32'(exp_q.pop_front()));
    end
    bus.req = bus.req & ~d;
  endtask

  task automatic run_div(input int t, input logic [DW-1:0] a, input logic [DW-1:0] b,
                         input logic [DW-1:0] r, input int exp_lat);
    logic [THREADS-1:0] d;
    int lat, busy_n;
    logic [1:0] g;
    set_ops(t, a, b);
    expect_done(t, r);
    bus.req[t] = 1'b1;
    wait_done(d, lat, busy_n, g);
    check("grant_id", 32'(g), 32'(t));
    check("done_latency", 32'(lat), 32'(exp_lat));
    check("busy_cycles", 32'(busy_n), 32'(exp_lat + 1));
    sb_done(d);
    @(negedge clk);
    check("done_one_cycle", 32'(bus.done), 0);
    check("back_to_idle", 32'(dbg_state), 32'(S_IDLE));
    check("busy_low", 32'(bus.busy), 0);
  endtask

  initial begin
    logic [THREADS-1:0] d;
    int lat, busy_n;
    logic [1:0] g;

    reset   = 1'b0;
    bus.req = '0;
    bus.rs  = '0;
    bus.rt  = '0;
    #1;
    check("rst_done", 32'(bus.done), 0);
    check("rst_result", 32'(bus.result), 0);
    check("rst_busy", 32'(bus.busy), 0);
    check("rst_grant", 32'(bus.grant_id), 0);
    check("rst_state", 32'(dbg_state), 32'(S_IDLE));
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    // done is seen after the ninth edge past the grant: the tenth busy cycle
    run_div(0, 8'd100, 8'd7, 8'h0E, 9);

    run_div(1, 8'hF9, 8'h02, 8'hFD, 9);   // -7 / 2
    run_div(2, 8'h07, 8'hFE, 8'hFD, 9);   // 7 / -2
    run_div(3, 8'hF9, 8'hFE, 8'h03, 9);   // -7 / -2
    run_div(0, 8'h80, 8'hFF, 8'h80, 9);   // -128 / -1 wraps
    run_div(1, 8'h80, 8'h01, 8'h80, 9);   // -128 / 1

    // divide by zero: done right after the grant edge
    run_div(2, 8'd5, 8'd0, 8'hFF, 0);

    // all four requesting from a fresh reset: order 0,1,2,3
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    set_ops(0, 8'd20, 8'd3);   expect_done(0, 8'h06);
    set_ops(1, 8'hEC, 8'd3);   expect_done(1, 8'hFA);
    set_ops(2, 8'd9, 8'hFC);   expect_done(2, 8'hFE);
    set_ops(3, 8'd127, 8'd127); expect_done(3, 8'h01);
    bus.req = 4'hF;
    for (int n = 0; n < 4; n++) begin
      wait_done(d, lat, busy_n, g);
      sb_done(d);
    end
    @(negedge clk);

    // last = 3: thread 0 beats thread 1
    set_ops(0, 8'd50, 8'd5);   expect_done(0, 8'h0A);
    set_ops(1, 8'hCE, 8'd5);   expect_done(1, 8'hF6);
    bus.req = 4'b0011;
    for (int n = 0; n < 2; n++) begin
      wait_done(d, lat, busy_n, g);
      sb_done(d);
    end
    @(negedge clk);

    // operands changed after the grant+3 edge must not matter
    set_ops(1, 8'd60, 8'd4);
    expect_done(1, 8'h0F);
    bus.req[1] = 1'b1;
    repeat (4) @(negedge clk);
    set_ops(1, 8'h9C, 8'h01);
    wait_done(d, lat, busy_n, g);
    check("late_ops_latency", 32'(lat), 5);
    sb_done(d);
    @(negedge clk);

    // reset during ITER cycle 4, then thread 0 priority restored
    set_ops(0, 8'hA6, 8'd9);
    bus.req[0] = 1'b1;
    repeat (5) @(negedge clk);
    check("pre_reset_state", 32'(dbg_state), 32'(S_ITER));
    reset = 1'b0;
    #1;
    check("abort_busy", 32'(bus.busy), 0);
    check("abort_done", 32'(bus.done), 0);
    check("abort_result", 32'(bus.result), 0);
    check("abort_state", 32'(dbg_state), 32'(S_IDLE));
    @(negedge clk);
    check("abort_no_done", 32'(bus.done), 0);
    reset = 1'b1;
    set_ops(1, 8'd33, 8'hFD);
    expect_done(0, 8'hF6);
    expect_done(1, 8'hF5);
    bus.req[1] = 1'b1;
    for (int n = 0; n < 2; n++) begin
      wait_done(d, lat, busy_n, g);
      sb_done(d);
    end
    @(negedge clk);
    check("queue_drained", 32'(exp_q.size()), 0);

    // final report
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
